ahb_s_mem: RTL and testbench
============================

// Module: ahb_s_mem
// PURPOSE
//  AHB-Lite slave (responder) backed by on-chip byte-addressable memory; the far end of ahb_m.
//  Accepts pipelined address/data-phase transfers, inserts programmable wait states,
//  returns OKAY/ERROR responses. Serves as bus target for master bring-up and system sims.
// PARAMETERS
//  ADDRW        32    haddr width
//  DATAW        32    data bus width (only 32 supported)
//  MEM_BYTES    1024  memory size in bytes, power of 2, >= 4
//  WAIT_CYCLES  0     wait states inserted per data phase (0..15)
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  reset      in   1      asynchronous, active-high reset
//  hsel       in   1      slave select
//  haddr      in   ADDRW  byte address (address phase)
//  htrans     in   2      IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hwrite     in   1      1=write, 0=read
//  hsize      in   3      000 byte, 001 half, 010 word
//  hwdata     in   DATAW  write data (data phase)
//  hready     in   1      bus-level ready (previous transfer complete)
//  hreadyout  out  1      this slave's data-phase ready
//  hresp      out  1      0=OKAY 1=ERROR
//  hrdata     out  DATAW  read data, valid when hreadyout=1 in a read data phase
// BEHAVIOUR
//  - Reset: hreadyout=1, hresp=0, hrdata=0, FSM=ST_IDLE, wait counter=0. Memory NOT cleared.
//  - Accept: address phase captured (haddr, hwrite, hsize) when hsel & hready & htrans[1].
//    IDLE/BUSY or hsel=0 -> no transfer, zero-wait OKAY.
//  - FSM: ST_IDLE -> ST_WAIT on accept if WAIT_CYCLES>0 (hreadyout=0 for exactly
//    WAIT_CYCLES cycles), then data cycle with hreadyout=1. WAIT_CYCLES=0 -> data
//    phase completes in the cycle after the address phase. Erroring transfer ->
//    ST_ERR1 (hreadyout=0, hresp=1) -> ST_ERR2 (hreadyout=1, hresp=1) -> ST_IDLE or next.
//    Error detected at capture: no wait states inserted.
//  - New address phase accepted in the completing data cycle (hreadyout=1) -> back-to-back,
//    no idle bubble. Transfer accepted during ST_ERR2 handled normally.
//  - Write: hwdata sampled in the data cycle with hreadyout=1; little-endian byte lanes
//    from hsize and addr[1:0]; only enabled lanes updated.
//  - Read: hrdata = memory word at captured addr[..:2], full word on all lanes, driven
//    only in completing read data cycle; otherwise 0.
//  - Write then read same address back-to-back: read returns new data (write commits at
//    end of write data phase, before read data phase).
//  - Wait counter: width $clog2(WAIT_CYCLES+1); reloads on each accept, no wrap.
//  - Reset mid-transfer: outputs return to reset values immediately; pending write discarded.
// CONFIGURATION
//  AHB_S_MEM_ERR_EN defined: ERROR response for haddr >= MEM_BYTES, hsize > 010,
//    or misalignment (half: addr[0]=1; word: addr[1:0]!=0). No memory update on error.
//  Undefined: hresp tied 0, ERR states absent; address used modulo MEM_BYTES; hsize>010
//    treated as word; misaligned low address bits ignored (aligned down).
// STRUCTURE
//  ahb_pkg: htrans_t enum (IDLE/BUSY/NONSEQ/SEQ), hsize_t enum, HRESP_OKAY/HRESP_ERROR
//    constants, state_t (ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2). Shared with ahb_m.
//  Sub-module ahb_s_ram: MEM_BYTES/4 x 32 array, 4-bit byte write-enable, async read.
//  Top holds capture regs, FSM, wait counter, lane decode, error check.
// TESTING
//  1. WAIT_CYCLES=0: NONSEQ write 0xDEADBEEF @0x10, then read @0x10 -> hrdata=0xDEADBEEF,
//     hreadyout=1 every cycle, hresp=0.
//  2. Word 0x11223344 @0x10; byte write 0xAB (on lane 3) @0x13; read @0x10 -> 0xAB223344.
//  3. WAIT_CYCLES=2: read @0x04 -> hreadyout=0 for exactly 2 cycles, then 1 with data.
//  4. ERR_EN, MEM_BYTES=1024: write @0x400 -> cycle1 hreadyout=0/hresp=1, cycle2 1/1, memory
//     unchanged; without macro the write lands @0x000, hresp=0.
//  5. WAIT_CYCLES=3: assert reset during 2nd wait cycle of write @0x20 -> hreadyout=1,
//     hresp=0, hrdata=0 at once; later read @0x20 returns pre-write value.
//  6. Pipelined: write 0x5A5A5A5A @0x24 then immediately read @0x24 -> 0x5A5A5A5A; htrans=IDLE
//     or hsel=0 -> OKAY, zero wait, no memory change.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and slave state type shared by ahb_s_mem and ahb_m.
// Also provides byte-lane helpers used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    // Little-endian byte enables; misaligned low bits are aligned down,
    // sizes above a word are treated as a word.
    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << addr_lo;
            3'b001:  be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                m[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                m[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ahb_s_ram.sv
// ahb_s_ram: word-organised storage for ahb_s_mem with per-byte write enables
// and an asynchronous read port. Contents are not affected by reset.
module ahb_s_ram #(
    parameter int WORDS = 256,
    parameter int WAW   = 8
) (
    input  logic           clk,
    input  logic [3:0]     i_we,
    input  logic [WAW-1:0] i_waddr,
    input  logic [31:0]    i_wdata,
    input  logic [WAW-1:0] i_raddr,
    output logic [31:0]    o_rdata
);

    logic [31:0] r_mem [WORDS];

    // Byte-lane write; memory deliberately survives reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_s_mem.sv
// ahb_s_mem: AHB-Lite memory slave with programmable wait states.
// Optional feature macro: AHB_S_MEM_ERR_EN -- when defined, out-of-range,
// oversized or misaligned transfers get a two-cycle ERROR response and do
// not touch memory; when undefined, hresp is always OKAY, addresses wrap
// modulo MEM_BYTES and misaligned low address bits are ignored.
module ahb_s_mem
    import ahb_pkg::*;
#(
    parameter int ADDRW       = 32,
    parameter int DATAW       = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsel,
    input  logic [ADDRW-1:0] haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [DATAW-1:0] hwdata,
    input  logic             hready,
    output logic             hreadyout,
    output logic             hresp,
    output logic [DATAW-1:0] hrdata
);

    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int WAW    = (MEM_AW > 2) ? MEM_AW - 2 : 1;
    localparam int WORDS  = MEM_BYTES / 4;
    localparam int WCW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t           r_state;
    logic             r_hreadyout;
    logic             r_hresp;
    logic [DATAW-1:0] r_hrdata;
    logic [WCW-1:0]   r_wcnt;
    logic             r_dphase;
    logic [WAW-1:0]   r_addr_word;
    logic [1:0]       r_addr_lo;
    logic             r_write;
    logic [2:0]       r_size;

    logic             w_accept;
    logic             w_err;
    logic [WAW-1:0]   w_haddr_word;
    logic [WAW-1:0]   w_raddr;
    logic [3:0]       w_we;
    logic [31:0]      w_ram_rdata;
    logic [31:0]      w_rd_data;
    logic             w_unused_addr;

    // A transfer is only taken while this slave is not stalling the bus.
    assign w_accept     = hsel & hready & htrans[1] & r_hreadyout;
    assign w_haddr_word = haddr[WAW+1:2];
    assign w_unused_addr = ^haddr;

`ifdef AHB_S_MEM_ERR_EN
    assign w_err = (haddr >= ADDRW'(MEM_BYTES))
                 | (hsize > 3'b010)
                 | ((hsize == 3'b001) & haddr[0])
                 | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    // Write commits at the end of the completing write data cycle.
    assign w_we = (r_dphase && r_write) ? lane_be(r_size, r_addr_lo) : 4'b0000;

    // Waited reads fetch the captured address; zero-wait reads the bus address.
    assign w_raddr = (r_state == ST_WAIT) ? r_addr_word : w_haddr_word;

    // Forward a committing write so a back-to-back read sees the new data.
    assign w_rd_data = ((w_we != 4'b0000) && (r_addr_word == w_raddr))
                     ? lane_merge(w_ram_rdata, hwdata, w_we) : w_ram_rdata;

    ahb_s_ram #(
        .WORDS (WORDS),
        .WAW   (WAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_addr_word),
        .i_wdata (hwdata),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata)
    );

    // Transfer FSM: capture, wait-state count, error sequence and registered responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_hrdata    <= {DATAW{1'b0}};
            r_wcnt      <= {WCW{1'b0}};
            r_dphase    <= 1'b0;
            r_addr_word <= {WAW{1'b0}};
            r_addr_lo   <= 2'b00;
            r_write     <= 1'b0;
            r_size      <= 3'b000;
        end else begin
            r_dphase <= 1'b0;
            r_hrdata <= {DATAW{1'b0}};
            if (w_accept) begin
                r_addr_word <= w_haddr_word;
                r_addr_lo   <= haddr[1:0];
                r_write     <= hwrite;
                r_size      <= hsize;
                r_wcnt      <= WCW'(WAIT_CYCLES);
                if (w_err) begin
                    r_state     <= ST_ERR1;
                    r_hreadyout <= 1'b0;
                    r_hresp     <= HRESP_ERROR;
                end else if (WAIT_CYCLES > 0) begin
                    r_state     <= ST_WAIT;
                    r_hreadyout <= 1'b0;
                    r_hresp     <= HRESP_OKAY;
                end else begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                    r_dphase    <= 1'b1;
                    r_hrdata    <= hwrite ? {DATAW{1'b0}} : w_rd_data;
                end
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (r_wcnt <= WCW'(1)) begin
                            r_state     <= ST_IDLE;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                            r_dphase    <= 1'b1;
                            r_wcnt      <= {WCW{1'b0}};
                            r_hrdata    <= r_write ? {DATAW{1'b0}} : w_rd_data;
                        end else begin
                            r_wcnt <= r_wcnt - WCW'(1);
                        end
                    end
`ifdef AHB_S_MEM_ERR_EN
                    ST_ERR1: begin
                        r_state     <= ST_ERR2;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_ERROR;
                    end
                    ST_ERR2: begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
`endif
                    default: begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                endcase
            end
        end
    end

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    assign hrdata    = r_hrdata;

endmodule

// File: tb/tb_ahb_s_mem.sv
// tb_ahb_s_mem: directed self-checking bench for ahb_s_mem.
// u0 runs with zero wait states, u3 with three; each slave's hready is its own hreadyout.
module tb_ahb_s_mem;

    logic        clk;
    logic        rst0, rst3;
    logic        hsel0, hsel3;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready0, hreadyout0, hresp0;
    logic        hready3, hreadyout3, hresp3;
    logic [31:0] hrdata0, hrdata3;

    int checks = 0;
    int errors = 0;

    assign hready0 = hreadyout0;
    assign hready3 = hreadyout3;

    ahb_s_mem #(.ADDRW(32), .DATAW(32), .MEM_BYTES(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(rst0), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready0),
        .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_s_mem #(.ADDRW(32), .DATAW(32), .MEM_BYTES(1024), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset(rst3), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready3),
        .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] sz);
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle();
        htrans = 2'b00;
    endtask

    initial begin
        rst0 = 1'b1; rst3 = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0;
        haddr = 32'h0; hwdata = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
        #3;
        chk("rst_rdy0", {31'd0, hreadyout0}, 32'd1);
        chk("rst_resp0", {31'd0, hresp0}, 32'd0);
        chk("rst_rdata0", hrdata0, 32'h0);
        chk("rst_rdy3", {31'd0, hreadyout3}, 32'd1);
        step(); step();
        rst0 = 1'b0; rst3 = 1'b0;
        step();

        // 1: zero-wait word write then read with an idle cycle between
        hsel0 = 1'b1;
        ap(32'h10, 1'b1, 3'b010);
        step();
        chk("t1_wr_rdy", {31'd0, hreadyout0}, 32'd1);
        chk("t1_wr_resp", {31'd0, hresp0}, 32'd0);
        hwdata = 32'hDEADBEEF; idle();
        step();
        chk("t1_idle_rdy", {31'd0, hreadyout0}, 32'd1);
        ap(32'h10, 1'b0, 3'b010);
        step();
        chk("t1_rd_data", hrdata0, 32'hDEADBEEF);
        chk("t1_rd_rdy", {31'd0, hreadyout0}, 32'd1);
        idle();
        step();
        chk("t1_rd_after", hrdata0, 32'h0);

        // 2: word, lane-3 byte, forwarded read; then half-word on upper lanes
        ap(32'h10, 1'b1, 3'b010);
        step();
        hwdata = 32'h11223344; ap(32'h13, 1'b1, 3'b000);
        step();
        chk("t2_wr_rdata0", hrdata0, 32'h0);
        hwdata = 32'hAB999999; ap(32'h10, 1'b0, 3'b010);
        step();
        chk("t2_byte_fwd", hrdata0, 32'hAB223344);
        ap(32'h14, 1'b1, 3'b010);
        step();
        hwdata = 32'h55667788; ap(32'h16, 1'b1, 3'b001);
        step();
        hwdata = 32'hCAFE1111; idle();
        step();
        ap(32'h14, 1'b0, 3'b010);
        step();
        chk("t2_half", hrdata0, 32'hCAFE7788);
        idle();
        step();

        // 4: write beyond MEM_BYTES
        ap(32'h0, 1'b1, 3'b010);
        step();
        hwdata = 32'hA5A5A5A5; ap(32'h400, 1'b1, 3'b010);
        step();
`ifdef AHB_S_MEM_ERR_EN
        chk("t4_err1_rdy", {31'd0, hreadyout0}, 32'd0);
        chk("t4_err1_resp", {31'd0, hresp0}, 32'd1);
        hwdata = 32'h12345678; idle();
        step();
        chk("t4_err2_rdy", {31'd0, hreadyout0}, 32'd1);
        chk("t4_err2_resp", {31'd0, hresp0}, 32'd1);
        step();
        chk("t4_err_done", {31'd0, hresp0}, 32'd0);
        ap(32'h0, 1'b0, 3'b010);
        step();
        chk("t4_mem", hrdata0, 32'hA5A5A5A5);
`else
        chk("t4_wrap_rdy", {31'd0, hreadyout0}, 32'd1);
        chk("t4_wrap_resp", {31'd0, hresp0}, 32'd0);
        hwdata = 32'h12345678; idle();
        step();
        ap(32'h0, 1'b0, 3'b010);
        step();
        chk("t4_mem", hrdata0, 32'h12345678);
`endif
        idle();
        step();

        // 6: pipelined write/read, then IDLE, hsel=0 and BUSY leave memory alone
        ap(32'h24, 1'b1, 3'b010);
        step();
        hwdata = 32'h5A5A5A5A; ap(32'h24, 1'b0, 3'b010);
        step();
        chk("t6_pipe", hrdata0, 32'h5A5A5A5A);
        chk("t6_pipe_resp", {31'd0, hresp0}, 32'd0);
        haddr = 32'h24; hwrite = 1'b1; htrans = 2'b00;
        step();
        chk("t6_idle_rdy", {31'd0, hreadyout0}, 32'd1);
        chk("t6_idle_rdata", hrdata0, 32'h0);
        hwdata = 32'hFFFFFFFF; hsel0 = 1'b0; ap(32'h24, 1'b1, 3'b010);
        step();
        chk("t6_nosel_rdy", {31'd0, hreadyout0}, 32'd1);
        hsel0 = 1'b1; htrans = 2'b01;
        step();
        chk("t6_busy_resp", {31'd0, hresp0}, 32'd0);
        ap(32'h24, 1'b0, 3'b010);
        step();
        chk("t6_unchanged", hrdata0, 32'h5A5A5A5A);
        idle(); hsel0 = 1'b0;
        step();

        // 3: three wait states on write and read
        hsel3 = 1'b1;
        ap(32'h04, 1'b1, 3'b010);
        step();
        hwdata = 32'h0F0E0D0C; idle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_wr_wait", {31'd0, hreadyout3}, 32'd0);
            step();
        end
        chk("t3_wr_done", {31'd0, hreadyout3}, 32'd1);
        step();
        ap(32'h04, 1'b0, 3'b010);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t3_rd_wait", {31'd0, hreadyout3}, 32'd0);
            chk("t3_rd_wait_data", hrdata3, 32'h0);
            step();
        end
        chk("t3_rd_rdy", {31'd0, hreadyout3}, 32'd1);
        chk("t3_rd_data", hrdata3, 32'h0F0E0D0C);
        step();
        chk("t3_rd_after", hrdata3, 32'h0);

        // 5: reset during the second wait cycle discards the write
        ap(32'h20, 1'b1, 3'b010);
        step();
        hwdata = 32'h13572468; idle();
        repeat (4) step();
        ap(32'h20, 1'b1, 3'b010);
        step();
        hwdata = 32'hFFFF0000; idle();
        step();
        #2 rst3 = 1'b1;
        #1;
        chk("t5_rst_rdy", {31'd0, hreadyout3}, 32'd1);
        chk("t5_rst_resp", {31'd0, hresp3}, 32'd0);
        chk("t5_rst_rdata", hrdata3, 32'h0);
        step(); step();
        rst3 = 1'b0;
        step();
        ap(32'h20, 1'b0, 3'b010);
        step();
        idle();
        repeat (3) step();
        chk("t5_rd_rdy", {31'd0, hreadyout3}, 32'd1);
        chk("t5_old_data", hrdata3, 32'h13572468);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
